// File: rtl/result_collector.sv
// Captures SVM MAC accumulator outputs into a per-instance result buffer,
// tagging each entry with a valid bit and a sign-derived class label.
module result_collector #(
    parameter int ACCUM_SIZE = 64,
    parameter int MAX_FEAT   = 16,
    parameter int MAX_SV     = 64,
    parameter int NUM_INST   = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [$clog2(MAX_SV+1)-1:0]              cfg_num_sv,
    input  logic [$clog2(MAX_FEAT+1)-1:0]            cfg_num_feat,
    input  logic [$clog2(NUM_INST+1)-1:0]            cfg_num_inst,
    input  logic                                     in_valid,
    input  logic [ACCUM_SIZE-1:0]                    result,
    output logic [NUM_INST-1:0][ACCUM_SIZE-1:0]      results,
    output logic [NUM_INST-1:0]                      result_valid,
    output logic [NUM_INST-1:0]                      labels,
    output logic                                     wr_pulse,
    output logic [$clog2(NUM_INST)-1:0]              wr_index,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err
);

    localparam int SW = $clog2(MAX_SV+1);
    localparam int FW = $clog2(MAX_FEAT+1);
    localparam int IW = $clog2(NUM_INST+1);
    localparam int XW = $clog2(NUM_INST);
    localparam int PW = $clog2(MAX_SV*MAX_FEAT+1);

    localparam logic [SW-1:0] SV_MAX   = SW'(MAX_SV);
    localparam logic [FW-1:0] FEAT_MAX = FW'(MAX_FEAT);
    localparam logic [IW-1:0] INST_MAX = IW'(NUM_INST);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        LATER
    } state_t;

    state_t state, next_state;

    logic [SW-1:0]    sv_q;
    logic [IW-1:0]    inst_q;
    logic [PW-1:0]    fill_q;
    logic [PW-1:0]    cnt;
    logic [IW-1:0]    idx;

    logic             cfg_ok;
    logic [SW+FW-1:0] prod;
    logic             accept;
    logic             reject;
    logic             capture;
    logic             finish;
    logic [IW-1:0]    cap_idx;

    always_comb begin
        cfg_ok = (cfg_num_sv != '0) && (cfg_num_sv <= SV_MAX)
              && (cfg_num_feat != '0) && (cfg_num_feat <= FEAT_MAX)
              && (cfg_num_inst != '0) && (cfg_num_inst <= INST_MAX);
        prod = {{FW{1'b0}}, cfg_num_sv} * {{SW{1'b0}}, cfg_num_feat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        cap_idx    = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        accept     = 1'b1;
                        next_state = FIRST;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FIRST: begin
                reject = start;
                if (in_valid && (cnt + PW'(1) == fill_q)) begin
                    capture = 1'b1;
                    if (inst_q == IW'(1)) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = LATER;
                    end
                end
            end
            LATER: begin
                reject = start;
                if (in_valid && (cnt + PW'(1) == PW'(sv_q))) begin
                    capture = 1'b1;
                    cap_idx = idx;
                    if (idx + IW'(1) == inst_q) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q         <= '0;
            inst_q       <= '0;
            fill_q       <= '0;
            cnt          <= '0;
            idx          <= '0;
            results      <= '0;
            result_valid <= '0;
            labels       <= '0;
            wr_pulse     <= 1'b0;
            wr_index     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wr_pulse <= capture;
            done     <= finish;
            busy     <= (next_state != IDLE);
            if (capture) begin
                wr_index <= cap_idx[XW-1:0];
                idx      <= cap_idx + IW'(1);
            end
            if (accept) begin
                sv_q         <= cfg_num_sv;
                inst_q       <= cfg_num_inst;
                fill_q       <= PW'(prod);
                cnt          <= '0;
                idx          <= '0;
                result_valid <= '0;
                err          <= 1'b0;
            end else if (reject) begin
                err <= 1'b1;
            end
            // Count freezes on idle beats; a capture resets it before wrap.
            if (state != IDLE && in_valid) begin
                cnt <= capture ? '0 : cnt + PW'(1);
            end
            for (int k = 0; k < NUM_INST; k++) begin
                if (capture && cap_idx == IW'(k)) begin
                    results[k]      <= result;
                    result_valid[k] <= 1'b1;
                    labels[k]       <= ~result[ACCUM_SIZE-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector.
module tb_result_collector;

    localparam int AW = 64;
    localparam int MF = 16;
    localparam int MS = 64;
    localparam int NI = 8;
    localparam int SW = $clog2(MS+1);
    localparam int FW = $clog2(MF+1);
    localparam int IW = $clog2(NI+1);
    localparam int XW = $clog2(NI);

    localparam logic [AW-1:0] M5 = -64'sd5;
    localparam logic [AW-1:0] M6 = -64'sd6;
    localparam logic [AW-1:0] M1 = -64'sd1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [SW-1:0]          cfg_num_sv;
    logic [FW-1:0]          cfg_num_feat;
    logic [IW-1:0]          cfg_num_inst;
    logic                   in_valid;
    logic [AW-1:0]          result;
    logic [NI-1:0][AW-1:0]  results;
    logic [NI-1:0]          result_valid;
    logic [NI-1:0]          labels;
    logic                   wr_pulse;
    logic [XW-1:0]          wr_index;
    logic                   busy;
    logic                   done;
    logic                   err;

    int checks = 0;
    int errors = 0;
    int caps;

    result_collector #(
        .ACCUM_SIZE(AW),
        .MAX_FEAT(MF),
        .MAX_SV(MS),
        .NUM_INST(NI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_num_sv(cfg_num_sv),
        .cfg_num_feat(cfg_num_feat),
        .cfg_num_inst(cfg_num_inst),
        .in_valid(in_valid),
        .result(result),
        .results(results),
        .result_valid(result_valid),
        .labels(labels),
        .wr_pulse(wr_pulse),
        .wr_index(wr_index),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [AW-1:0] obs,
                       input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int sv, input int feat, input int inst);
        start        = 1'b1;
        in_valid     = 1'b0;
        cfg_num_sv   = SW'(sv);
        cfg_num_feat = FW'(feat);
        cfg_num_inst = IW'(inst);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        result = '0;
        cfg_num_sv = '0;
        cfg_num_feat = '0;
        cfg_num_inst = '0;
        tick();
        tick();
        chk("rst_busy", AW'(busy), 0);
        chk("rst_done", AW'(done), 0);
        chk("rst_err", AW'(err), 0);
        chk("rst_wr", AW'(wr_pulse), 0);
        chk("rst_rv", AW'(result_valid), 0);
        chk("rst_res0", results[0], 0);
        rst = 1'b0;

        // Continuous beats, sv=3 feat=2 inst=2
        go(3, 2, 2);
        tick();
        start = 1'b0;
        chk("t1_busy_rise", AW'(busy), 1);
        for (int b = 1; b <= 9; b++) begin
            in_valid = 1'b1;
            result = AW'(b);
            tick();
            chk($sformatf("t1_wr_%0d", b), AW'(wr_pulse), AW'(b == 6 || b == 9));
            chk($sformatf("t1_done_%0d", b), AW'(done), AW'(b == 9));
            chk($sformatf("t1_busy_%0d", b), AW'(busy), AW'(b != 9));
            if (b == 6) begin
                chk("t1_res0_early", results[0], 6);
                chk("t1_idx0", AW'(wr_index), 0);
            end
        end
        chk("t1_res0", results[0], 6);
        chk("t1_res1", results[1], 9);
        chk("t1_rv", AW'(result_valid), 3);
        chk("t1_lab", AW'(labels), 3);
        chk("t1_idx1", AW'(wr_index), 1);

        // Start in the done cycle, in_valid on every other cycle
        go(3, 2, 2);
        tick();
        start = 1'b0;
        chk("t2_err", AW'(err), 0);
        chk("t2_busy", AW'(busy), 1);
        chk("t2_rv_clr", AW'(result_valid), 0);
        for (int c = 1; c <= 18; c++) begin
            in_valid = (c % 2 == 0);
            result = in_valid ? AW'(c / 2) : AW'(16'hdead);
            tick();
            chk($sformatf("t2_wr_%0d", c), AW'(wr_pulse), AW'(c == 12 || c == 18));
            chk($sformatf("t2_done_%0d", c), AW'(done), AW'(c == 18));
            chk($sformatf("t2_busy_%0d", c), AW'(busy), AW'(c != 18));
        end
        in_valid = 1'b0;
        chk("t2_res0", results[0], 6);
        chk("t2_res1", results[1], 9);
        chk("t2_rv", AW'(result_valid), 3);

        // Labels from signed captures
        go(2, 1, 4);
        tick();
        start = 1'b0;
        caps = 0;
        for (int b = 1; b <= 8; b++) begin
            in_valid = 1'b1;
            case (b)
                2: result = M5;
                4: result = 7;
                6: result = 0;
                8: result = M1;
                default: result = 100;
            endcase
            tick();
            caps += int'(wr_pulse);
        end
        in_valid = 1'b0;
        chk("t3_caps", AW'(caps), 4);
        chk("t3_done", AW'(done), 1);
        chk("t3_lab", AW'(labels), 8'h06);
        chk("t3_rv", AW'(result_valid), 8'h0f);
        chk("t3_res0", results[0], M5);
        chk("t3_res2", results[2], 0);
        chk("t3_res3", results[3], M1);
        chk("t3_idx", AW'(wr_index), 3);

        // Rejected starts leave the buffer alone
        go(0, 2, 2);
        tick();
        start = 1'b0;
        chk("t4_err_sv0", AW'(err), 1);
        chk("t4_busy_sv0", AW'(busy), 0);
        chk("t4_rv_sv0", AW'(result_valid), 8'h0f);
        chk("t4_res0_sv0", results[0], M5);
        tick();
        chk("t4_busy_hold", AW'(busy), 0);
        go(1, 1, NI + 1);
        tick();
        start = 1'b0;
        chk("t4_err_inst", AW'(err), 1);
        chk("t4_busy_inst", AW'(busy), 0);
        chk("t4_lab_inst", AW'(labels), 8'h06);
        chk("t4_rv_inst", AW'(result_valid), 8'h0f);

        // Valid start clears err; second start mid-run is rejected
        go(1, 3, 2);
        tick();
        start = 1'b0;
        chk("t5_err_clr", AW'(err), 0);
        chk("t5_busy", AW'(busy), 1);
        chk("t5_rv_clr", AW'(result_valid), 0);
        for (int b = 1; b <= 4; b++) begin
            in_valid = 1'b1;
            result = AW'(9 + b);
            if (b == 2) begin
                start = 1'b1;
                cfg_num_sv = SW'(5);
                cfg_num_feat = FW'(5);
                cfg_num_inst = IW'(5);
            end else begin
                start = 1'b0;
            end
            tick();
            if (b == 2) chk("t5_err_mid", AW'(err), 1);
            chk($sformatf("t5_done_%0d", b), AW'(done), AW'(b == 4));
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("t5_res0", results[0], 12);
        chk("t5_res1", results[1], 13);
        chk("t5_rv", AW'(result_valid), 3);
        chk("t5_err_sticky", AW'(err), 1);
        chk("t5_busy_end", AW'(busy), 0);

        // Reset at beat 4 of a 6-beat fill
        go(3, 2, 1);
        tick();
        start = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            in_valid = 1'b1;
            result = AW'(b);
            rst = (b == 4);
            tick();
            chk($sformatf("t6_done_%0d", b), AW'(done), 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        chk("t6_busy", AW'(busy), 0);
        chk("t6_err", AW'(err), 0);
        chk("t6_rv", AW'(result_valid), 0);
        chk("t6_lab", AW'(labels), 0);
        chk("t6_res1", results[1], 0);
        chk("t6_wr", AW'(wr_pulse), 0);
        tick();
        chk("t6_done_after", AW'(done), 0);
        go(3, 2, 1);
        tick();
        start = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            in_valid = 1'b1;
            result = '0 - AW'(b);
            tick();
            chk($sformatf("t6b_wr_%0d", b), AW'(wr_pulse), AW'(b == 6));
            chk($sformatf("t6b_done_%0d", b), AW'(done), AW'(b == 6));
        end
        in_valid = 1'b0;
        chk("t6b_res0", results[0], M6);
        chk("t6b_lab", AW'(labels), 0);
        chk("t6b_rv", AW'(result_valid), 1);
        chk("t6b_busy", AW'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
